booth_mult_arbiter: RTL and testbench

Sequencer and arbiter that shares one Booth radix-2 multiplier datapath (the Q/A/M register set and its add/subtract/shift controller) between two requesters. It runs a round-robin grant and captures the winner's operands. It issues a one-cycle start to the multiplier, then waits for its completion with a watchdog timeout. The product is returned to the winning requester with a done pulse. It sits between the two requesting blocks and the multiplier's start/done interface.

---
 rtl/booth_mult_arbiter.sv | 161 ++++++++++++++++
 tb/tb_booth_mult_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end that shares one Booth radix-2 multiplier between two requesters.
// Captures the winner's operands, starts the multiplier, guards it with a watchdog and returns the product.
module booth_mult_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic                 err0,
    output logic                 err1,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 busy,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_m,
    output logic [WIDTH-1:0]     mul_q,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_prod
);
    // state  | meaning
    // S_IDLE | no operation; arbitrate and capture operands
    // S_ISSUE| one-cycle multiplier start, watchdog cleared
    // S_WAIT | waiting for mul_done, watchdog running
    // S_RESP | done pulse to the winner, product valid

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_last;
    logic                r_win;
    logic                w_win_sel;
    logic [1:0]          w_sel_oh;
    logic [1:0]          w_win_oh;
    logic [CW-1:0]       r_wdog, w_wdog_nxt, w_wdog_inc;
    logic [1:0]          r_gnt, w_gnt_nxt;
    logic [1:0]          r_done, w_done_nxt;
    logic [1:0]          r_err, w_err_nxt;
    logic                r_start, w_start_nxt;
    logic                r_busy;
    logic                w_latch_ops;
    logic                w_latch_prod;
    logic [2*WIDTH-1:0]  r_prod;
    logic [WIDTH-1:0]    r_m, r_q;

    // On a tie the requester that was not served last wins; a lone request always wins.
    always_comb begin
        if (req0 && req1) begin
            w_win_sel = ~r_last;
        end else begin
            w_win_sel = req1;
        end
    end

    assign w_sel_oh   = w_win_sel ? 2'b10 : 2'b01;
    assign w_win_oh   = r_win ? 2'b10 : 2'b01;
    assign w_wdog_inc = (r_wdog == CW'(TIMEOUT)) ? r_wdog : r_wdog + 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_wdog_nxt   = r_wdog;
        w_gnt_nxt    = r_gnt;
        w_done_nxt   = 2'b00;
        w_err_nxt    = 2'b00;
        w_start_nxt  = 1'b0;
        w_latch_ops  = 1'b0;
        w_latch_prod = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_state_nxt = S_ISSUE;
                    w_latch_ops = 1'b1;
                    w_start_nxt = 1'b1;
                    w_gnt_nxt   = w_sel_oh;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_wdog_nxt  = '0;
            end
            S_WAIT: begin
                w_wdog_nxt = w_wdog_inc;
                // Completion takes priority over a watchdog expiry in the same cycle.
                if (mul_done) begin
                    w_state_nxt  = S_RESP;
                    w_latch_prod = 1'b1;
                    w_done_nxt   = w_win_oh;
                end else if (w_wdog_inc == CW'(TIMEOUT)) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = w_win_oh;
                    w_gnt_nxt   = 2'b00;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 2'b00;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_win   <= 1'b0;
            r_wdog  <= '0;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_err   <= 2'b00;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_prod  <= '0;
            r_m     <= '0;
            r_q     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wdog  <= w_wdog_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_start <= w_start_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            if (w_latch_ops) begin
                r_win  <= w_win_sel;
                r_last <= w_win_sel;
                r_m    <= w_win_sel ? a1 : a0;
                r_q    <= w_win_sel ? b1 : b0;
            end
            if (w_latch_prod) begin
                r_prod <= mul_prod;
            end
        end
    end

    assign gnt0      = r_gnt[0];
    assign gnt1      = r_gnt[1];
    assign done0     = r_done[0];
    assign done1     = r_done[1];
    assign err0      = r_err[0];
    assign err1      = r_err[1];
    assign prod      = r_prod;
    assign busy      = r_busy;
    assign mul_start = r_start;
    assign mul_m     = r_m;
    assign mul_q     = r_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a behavioural multiplier of programmable latency.
module tb_booth_mult_arbiter;
    localparam int W = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0, req1;
    logic [W-1:0]    a0, b0, a1, b1;
    logic            gnt0, gnt1, done0, done1, err0, err1;
    logic [2*W-1:0]  prod;
    logic            busy, mul_start;
    logic [W-1:0]    mul_m, mul_q;
    logic            mul_done = 1'b0;
    logic [2*W-1:0]  mul_prod = 16'hDEAD;

    int checks = 0;
    int errors = 0;
    int mdl_lat = 0;
    int cd = -1;
    logic signed [2*W-1:0] prod_hold;

    booth_mult_arbiter #(.WIDTH(W), .TIMEOUT(24)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .prod(prod), .busy(busy),
        .mul_start(mul_start), .mul_m(mul_m), .mul_q(mul_q),
        .mul_done(mul_done), .mul_prod(mul_prod)
    );

    always #5 clk = ~clk;

    // Multiplier model: mul_done mdl_lat cycles after mul_start; mdl_lat=0 never answers.
    initial begin
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            mul_prod = 16'hDEAD;
            if (mul_start) begin
                cd = (mdl_lat > 0) ? mdl_lat : -1;
                prod_hold = $signed(mul_m) * $signed(mul_q);
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mul_done = 1'b1;
                    mul_prod = prod_hold;
                    cd = -1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance until a done/err pulse; n = cycles since the ISSUE sample.
    task automatic wait_resp(output int n, output logic [3:0] flags, output int starts);
        n = 0;
        starts = 0;
        do begin
            tick;
            n++;
            if (mul_start) starts++;
        end while (!(done0 || done1 || err0 || err1) && n < 80);
        flags = {done0, done1, err0, err1};
        if (flags == 4'b0000) check("resp_bound", 32'(n), 32'(0));
    endtask

    int         n, st, w;
    logic [3:0] fl;
    logic       seen;

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tick; tick;
        check("rst_outs", {gnt0, gnt1, done0, done1, err0, err1, mul_start, busy}, 8'h00);
        check("rst_prod", prod, 16'h0000);
        check("rst_ops", {mul_m, mul_q}, 16'h0000);
        rst = 1'b0;

        // single request
        req0 = 1'b1; a0 = 8'd3; b0 = 8'd5; mdl_lat = 17;
        tick;
        check("t1_issue", {mul_start, gnt0, gnt1, busy}, 4'b1101);
        check("t1_ops", {mul_m, mul_q}, 16'h0305);
        wait_resp(n, fl, st);
        check("t1_lat", n, 18);
        check("t1_flags", fl, 4'b1000);
        check("t1_prod", prod, 16'h000F);
        check("t1_gnt", {gnt0, gnt1}, 2'b10);
        check("t1_starts", st, 0);
        req0 = 1'b0;
        tick;
        check("t1_idle", {busy, gnt0, done0}, 3'b000);

        // tie after reset, alternation
        rst = 1'b1; tick; rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 8'd2; b0 = 8'd3; a1 = 8'd4; b1 = 8'd5; mdl_lat = 3;
        for (int i = 0; i < 4; i++) begin
            w = i % 2;
            tick;
            check("t2_gnt", {gnt0, gnt1}, (w == 1) ? 2'b01 : 2'b10);
            check("t2_ops", {mul_m, mul_q}, (w == 1) ? 16'h0405 : 16'h0203);
            wait_resp(n, fl, st);
            check("t2_lat", n, 4);
            check("t2_flags", fl, (w == 1) ? 4'b0100 : 4'b1000);
            check("t2_prod", prod, (w == 1) ? 16'd20 : 16'd6);
            if (i == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            tick;
            check("t2_idle", {busy, gnt0, gnt1}, 3'b000);
        end

        // negative operands, then pointer favours req0
        req1 = 1'b1; a1 = 8'hFC; b1 = 8'h07; mdl_lat = 5;
        tick;
        check("t3_issue", {gnt0, gnt1, mul_start}, 3'b011);
        check("t3_ops", {mul_m, mul_q}, 16'hFC07);
        wait_resp(n, fl, st);
        check("t3_lat", n, 6);
        check("t3_flags", fl, 4'b0100);
        check("t3_prod", prod, 16'hFFE4);
        req0 = 1'b1; a0 = 8'd3; b0 = 8'd3; mdl_lat = 2;
        tick;
        check("t3_idle", busy, 1'b0);
        tick;
        check("t3_ptr", {gnt0, gnt1}, 2'b10);
        wait_resp(n, fl, st);
        check("t3_flags2", fl, 4'b1000);
        check("t3_prod2", prod, 16'd9);
        req0 = 1'b0; req1 = 1'b0;
        tick;

        // timeout, then re-grant of the held request
        req0 = 1'b1; a0 = 8'd7; b0 = 8'd9; mdl_lat = 0;
        tick;
        check("t4_issue", {gnt0, gnt1}, 2'b10);
        wait_resp(n, fl, st);
        check("t4_lat", n, 25);
        check("t4_flags", fl, 4'b0010);
        check("t4_idle", {busy, gnt0}, 2'b00);
        check("t4_prod", prod, 16'd9);
        mdl_lat = 4;
        tick;
        check("t4_regrant", {gnt0, mul_start, err0}, 3'b110);
        wait_resp(n, fl, st);
        check("t4_lat2", n, 5);
        check("t4_flags2", fl, 4'b1000);
        check("t4_prod2", prod, 16'd63);
        req0 = 1'b0;
        tick;

        // done on the timeout cycle
        req0 = 1'b1; a0 = 8'hFF; b0 = 8'h02; mdl_lat = 24;
        tick;
        wait_resp(n, fl, st);
        check("t5_lat", n, 25);
        check("t5_flags", fl, 4'b1000);
        check("t5_prod", prod, 16'hFFFE);
        req0 = 1'b0;
        tick;
        check("t5_idle", {err0, done0, busy}, 3'b000);

        // reset mid-WAIT, late mul_done ignored
        req0 = 1'b1; a0 = 8'd5; b0 = 8'd5; mdl_lat = 10;
        tick;
        repeat (8) tick;
        check("t6_inwait", {busy, gnt0}, 2'b11);
        rst = 1'b1; req0 = 1'b0;
        tick;
        rst = 1'b0;
        check("t6_outs", {gnt0, gnt1, done0, done1, err0, err1, mul_start, busy}, 8'h00);
        check("t6_prod", prod, 16'h0000);
        check("t6_ops", {mul_m, mul_q}, 16'h0000);
        seen = 1'b0;
        repeat (5) begin
            tick;
            seen = seen | done0 | done1 | err0 | err1 | busy;
        end
        check("t6_ignored", seen, 1'b0);
        check("t6_prod_hold", prod, 16'h0000);
        req0 = 1'b1; req1 = 1'b1; a0 = 8'd1; b0 = 8'd2; a1 = 8'd6; b1 = 8'd6; mdl_lat = 2;
        tick;
        check("t6_tie", {gnt0, gnt1}, 2'b10);
        wait_resp(n, fl, st);
        check("t6_flags", fl, 4'b1000);
        check("t6_prod2", prod, 16'd2);
        req0 = 1'b0; req1 = 1'b0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
